// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: depth/pointer sizing, default thresholds
// and the registered status-flag bundle.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH    = 4;
  localparam int DEF_AFULL_MARGIN  = 2;
  localparam int DEF_AEMPTY_THRESH = 2;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

  function automatic int fifo_depth(input int aw);
    return 2 ** aw;
  endfunction

  // One extra bit so full and empty differ at equal indices
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write,
// asynchronous read. Contents are not reset.
module fifo_mem #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with count, threshold flags and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through read data.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = 8,
  parameter int AFULL_THRESH  = fifo_depth(ADDR_WIDTH) - DEF_AFULL_MARGIN,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  Wr_enable,
  input  logic                  Read_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH_C = PW'(fifo_depth(ADDR_WIDTH));
  localparam logic [PW-1:0] AF_C    = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AEMPTY_THRESH);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count_q;
  logic [PW-1:0]         count_d;
  fifo_flags_t           flags_q;
  fifo_flags_t           flags_d;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf_q;
  logic                  udf_q;
  logic [DATA_WIDTH-1:0] rd_data;

  fifo_mem #(
    .AW(ADDR_WIDTH),
    .DW(DATA_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr[ADDR_WIDTH-1:0]),
    .wdata(data_in),
    .raddr(rd_ptr[ADDR_WIDTH-1:0]),
    .rdata(rd_data)
  );

  // A simultaneous read frees the slot, so full does not block it
  always_comb begin
    rd_acc  = Read_enable && !flags_q.empty;
    wr_acc  = Wr_enable && (!flags_q.full || rd_acc);
    count_d = count_q + PW'(wr_acc) - PW'(rd_acc);
    flags_d        = '0;
    flags_d.full   = (count_d == DEPTH_C);
    flags_d.empty  = (count_d == '0);
    flags_d.afull  = (count_d >= AF_C);
    flags_d.aempty = (count_d <= AE_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      flags_q <= '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
      flags_q <= flags_d;
      ovf_q   <= Wr_enable && !wr_acc;
      udf_q   <= Read_enable && !rd_acc;
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out = flags_q.empty ? '0 : rd_data;
`else
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         dout_q <= '0;
    else if (rd_acc) dout_q <= rd_data;
  end

  assign data_out = dout_q;
`endif

  assign full         = flags_q.full;
  assign empty        = flags_q.empty;
  assign almost_full  = flags_q.afull;
  assign almost_empty = flags_q.aempty;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags, registered or FWFT read
// depending on FIFO_FWFT_EN.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = '0;
  logic       Wr_enable = 1'b0;
  logic       Read_enable = 1'b0;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];

  sync_fifo_flags dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .Wr_enable   (Wr_enable),
    .Read_enable (Read_enable),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    Wr_enable = 1'b1;
    data_in   = d;
    tick();
    Wr_enable = 1'b0;
    sb.push_back(d);
  endtask

  // Returns the word popped: seen before the edge in FWFT mode,
  // after the edge in registered mode.
  task automatic pop(output logic [7:0] v);
    Read_enable = 1'b1;
`ifdef FIFO_FWFT_EN
    v = data_out;
    tick();
`else
    tick();
    v = data_out;
`endif
    Read_enable = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] o;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    o = {count[3:0], empty, almost_empty, full, almost_full};
    checks++;
    if (o !== 8'b0000_1100) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00001100", o);
    end
    checks++;
    if ({data_out, overflow, underflow, count[4]} !== 11'd0) begin
      errors++;
      $display("FAIL reset_data: got dout=%0d ovf=%b udf=%b", data_out, overflow, underflow);
    end
  endtask

  task automatic test_underflow_empty();
    Read_enable = 1'b1;
    tick();
    Read_enable = 1'b0;
    checks++;
    if ({underflow, empty, count, data_out} !== {2'b11, 5'd0, 8'd0}) begin
      errors++;
      $display("FAIL udf_empty: got udf=%b empty=%b cnt=%0d dout=%0d expected 1 1 0 0",
               underflow, empty, count, data_out);
    end
    tick();
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL udf_pulse: got %b expected 0", underflow);
    end
  endtask

  task automatic test_basic();
    logic [7:0] v, e;
    logic [4:0] exp_cnt[4] = '{5'd1, 5'd2, 5'd1, 5'd0};
    push(8'd5);
    checks++;
    if (count !== exp_cnt[0]) begin
      errors++;
      $display("FAIL basic_cnt0: got %0d expected %0d", count, exp_cnt[0]);
    end
    push(8'd10);
    checks++;
    if (count !== exp_cnt[1]) begin
      errors++;
      $display("FAIL basic_cnt1: got %0d expected %0d", count, exp_cnt[1]);
    end
    for (int i = 2; i < 4; i++) begin
      pop(v);
      e = sb.pop_front();
      checks++;
      if (v !== e || count !== exp_cnt[i]) begin
        errors++;
        $display("FAIL basic_rd%0d: got d=%0d c=%0d expected d=%0d c=%0d",
                 i, v, count, e, exp_cnt[i]);
      end
    end
    Read_enable = 1'b1;
    tick();
    Read_enable = 1'b0;
`ifdef FIFO_FWFT_EN
    e = 8'd0;
`else
    e = 8'd10;
`endif
    checks++;
    if (underflow !== 1'b1 || data_out !== e || count !== 5'd0) begin
      errors++;
      $display("FAIL basic_udf: got udf=%b d=%0d c=%0d expected 1 %0d 0",
               underflow, data_out, count, e);
    end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] v, e;
    int bad;
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      checks++;
      if (full !== (i == 15)) begin
        errors++;
        $display("FAIL fill_full%0d: got %b expected %b", i, full, (i == 15));
      end
    end
    Wr_enable = 1'b1;
    data_in   = 8'd16;
    tick();
    Wr_enable = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pulse: got ovf=%b c=%0d full=%b expected 1 16 1",
               overflow, count, full);
    end
    tick();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_one_cycle: got %b expected 0", overflow);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      pop(v);
      e = sb.pop_front();
      if (v !== e) begin
        bad++;
        $display("FAIL fill_rd%0d: got %0d expected %0d", i, v, e);
      end
    end
    checks++;
    if (bad != 0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL fill_drain: got bad=%0d empty=%b expected 0 1", bad, empty);
    end
  endtask

  task automatic test_full_rw();
    logic [7:0] v, e;
    int bad;
    for (int i = 0; i < 16; i++) push(8'(100 + i));
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      Wr_enable   = 1'b1;
      Read_enable = 1'b1;
      data_in     = 8'd99;
`ifdef FIFO_FWFT_EN
      v = data_out;
      tick();
`else
      tick();
      v = data_out;
`endif
      e = sb.pop_front();
      sb.push_back(8'd99);
      checks++;
      if (v !== e || full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL full_rw%0d: got d=%0d f=%b c=%0d o=%b expected d=%0d f=1 c=16 o=0",
                 i, v, full, count, overflow, e);
      end
    end
    Wr_enable   = 1'b0;
    Read_enable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pop(v);
      e = sb.pop_front();
      if (v !== e) begin
        bad++;
        $display("FAIL full_rw_rd%0d: got %0d expected %0d", i, v, e);
      end
    end
    checks++;
    if (bad != 0 || count !== 5'd0) begin
      errors++;
      $display("FAIL full_rw_drain: got bad=%0d c=%0d expected 0 0", bad, count);
    end
  endtask

  task automatic test_thresholds();
    logic [7:0] v;
    for (int i = 1; i <= 16; i++) begin
      push(8'(i));
      checks++;
      if (almost_empty !== (i <= 2) || almost_full !== (i >= 14)) begin
        errors++;
        $display("FAIL thr_up%0d: got ae=%b af=%b expected ae=%b af=%b",
                 i, almost_empty, almost_full, (i <= 2), (i >= 14));
      end
    end
    for (int i = 15; i >= 0; i--) begin
      pop(v);
      void'(sb.pop_front());
      checks++;
      if (almost_empty !== (i <= 2) || almost_full !== (i >= 14)) begin
        errors++;
        $display("FAIL thr_dn%0d: got ae=%b af=%b expected ae=%b af=%b",
                 i, almost_empty, almost_full, (i <= 2), (i >= 14));
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] v, e;
    for (int i = 0; i < 7; i++) push(8'(50 + i));
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({count, empty, almost_empty, full, almost_full, overflow, underflow} !== 11'b00000_110000
        || data_out !== 8'd0) begin
      errors++;
      $display("FAIL async_rst: got c=%0d e=%b ae=%b f=%b af=%b d=%0d",
               count, empty, almost_empty, full, almost_full, data_out);
    end
    tick();
    rst = 1'b0;
    sb.delete();
    push(8'd42);
`ifdef FIFO_FWFT_EN
    checks++;
    if (data_out !== 8'd42) begin
      errors++;
      $display("FAIL fwft_visible: got %0d expected 42", data_out);
    end
`endif
    pop(v);
    e = sb.pop_front();
    checks++;
    if (v !== e || empty !== 1'b1) begin
      errors++;
      $display("FAIL rst_then_42: got d=%0d empty=%b expected %0d 1", v, empty, e);
    end
  endtask

  initial begin
    test_reset();
    test_underflow_empty();
    test_basic();
    test_fill_overflow();
    test_full_rw();
    test_thresholds();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Single-clock, parametrised FIFO with full/empty, programmable almost-full/almost-empty thresholds, an occupancy count and overflow/underflow error pulses. It buffers a DATA_WIDTH-bit stream between a producer and a consumer in the same clock domain. It sits where same-clock buffering is needed and extends the two-clock FIFO with status flags, error reporting and an optional first-word-fall-through read mode.

## Interface
Parameters:
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH entries (16)
- DATA_WIDTH, 8, word width
- AFULL_THRESH, DEPTH-2, almost_full asserted when count >= AFULL_THRESH
- AEMPTY_THRESH, 2, almost_empty asserted when count <= AEMPTY_THRESH

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- data_in  in  DATA_WIDTH  write data, sampled with Wr_enable
- Wr_enable  in  1  write request
- Read_enable  in  1  read request (pop)
- data_out  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_THRESH
- almost_empty  out  1  count <= AEMPTY_THRESH
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Pointers wr_ptr, rd_ptr are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits index memory, and natural binary wrap handles the rollover from entry DEPTH-1 to entry 0.
- Write accepted (wr_acc) = Wr_enable && (!full || rd_acc). Stores data_in at wr_ptr and increments wr_ptr.
- Read accepted (rd_acc) = Read_enable && !empty. Increments rd_ptr.
- Full and both requested: both accepted, count unchanged.
- Empty and both requested: write accepted, read rejected, underflow pulses. There is no bypass.
- Rejected write: data dropped, memory and pointers unchanged, overflow = 1 for that cycle only.
- Rejected read: data_out holds its value, underflow = 1 for that cycle only.
- count: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Flags are registered and computed from the next-state count, so they are valid in the same cycle as count.
- Reset state: pointers 0, count 0, data_out 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0. Memory contents are not reset.
- Reset mid-operation: all stored words are discarded immediately, with no drain.

## Timing
- Write to visible: count, empty and flags update at the write edge. The word is readable on the next cycle.
- Default read: data_out is registered. A read accepted at edge N presents the head word after edge N (1-cycle latency). data_out holds when no read is accepted.
- Throughput: one write and one read per cycle sustained.
- overflow and underflow are registered. They are high in the cycle after the offending request's edge, for exactly one cycle.

## Configuration
- Macro FIFO_FWFT_EN.
- Without it: registered read as described in Timing.
- With it: first-word-fall-through.
  - data_out = mem[rd_ptr] whenever !empty, so the head word is visible without a request. Read_enable pops it.
  - data_out = 0 while empty.
  - A write into an empty FIFO appears on data_out in the cycle after the write edge.
  - Flags, count and error rules are identical in both modes.

## Structure
- Package fifo_pkg: depth function (2**ADDR_WIDTH), default threshold constants, and a pointer-width helper. Shared with the two-clock FIFO.
- One sub-module, fifo_mem: simple dual-port register array with a synchronous write port and an asynchronous read port.
- The top level holds pointers, count, flags, error pulses and the data_out register or FWFT mux.

## Test plan
- Read while empty after reset -> data_out 0, underflow pulses once, count stays 0, empty stays 1.
- Write 5 then 10, then read twice -> data_out 5 then 10. A third read gives underflow with data_out holding 10. count goes 0→1→2→1→0.
- Write 0..16 continuously (17 writes) -> full after the 16th write, overflow pulses on the 17th. Reading 16 words returns 0..15 and value 16 never appears.
- Hold the FIFO full, assert Wr_enable and Read_enable together with data_in 99 for 4 cycles -> full stays 1, count stays 16, no overflow, and 99 is read back after the original 16 words.
- Thresholds at defaults -> almost_empty 1 for count ≤2, almost_full 1 for count ≥14. Check transitions at counts 2→3 and 13→14.
- Assert rst asynchronously mid-clock with count 7 -> all outputs take reset values immediately. The next write of 42 is read back as 42 (repeat with FIFO_FWFT_EN defined: 42 visible without Read_enable).
